// File: rtl/sw_pkg.sv
// Shared event-kind encoding and channel-field width helper for the switch debounce bank.
package sw_pkg;

    typedef enum logic [1:0] {
        PRESS   = 2'd0,
        RELEASE = 2'd1,
        LONG    = 2'd2
    } sw_evt_kind_e;

    function automatic int sw_chw(input int nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, symmetric DEPTH-sample debounce, edge pulses
// and (with SW_LONG_PRESS_EN defined) a saturating long-press counter.
module sw_debounce_ch #(
    parameter int DEPTH      = 3,
    parameter int ACT_LOW    = 0,
    parameter int LONG_TICKS = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cke,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);
    localparam logic IDLE = 1'(ACT_LOW);

    logic [1:0]       r_sync;
    logic [DEPTH-1:0] r_shift;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_n;
    logic             w_level_nxt;

    assign w_n = r_sync[1] ^ IDLE;

    // Mixed history holds the previous level, which is what makes the filter symmetric.
    always_comb begin
        w_level_nxt = r_level;
        if (&r_shift) begin
            w_level_nxt = 1'b1;
        end else if (~|r_shift) begin
            w_level_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= {2{IDLE}};
            r_shift   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_raw};
            if (i_cke) begin
                r_shift <= {r_shift[DEPTH-2:0], w_n};
            end
            r_level   <= w_level_nxt;
            r_press   <= w_level_nxt & ~r_level;
            r_release <= ~w_level_nxt & r_level;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef SW_LONG_PRESS_EN
    localparam int             CNTW  = $clog2(LONG_TICKS + 1);
    localparam logic [CNTW-1:0] LT    = CNTW'(LONG_TICKS);
    localparam logic [CNTW-1:0] LT_M1 = CNTW'(LONG_TICKS - 1);

    logic [CNTW-1:0] r_cnt;
    logic            r_long;

    // Saturation at LT guarantees a single long pulse per press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= r_level & i_cke & (r_cnt == LT_M1);
            if (!r_level) begin
                r_cnt <= '0;
            end else if (i_cke && (r_cnt != LT)) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce_bank.sv
// NCH-channel switch conditioner with merged valid/ready event stream and sticky overflow.
// Long-press support is built only when SW_LONG_PRESS_EN is defined.
module sw_debounce_bank
    import sw_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEPTH      = 3,
    parameter int ACT_LOW    = 0,
    parameter int LONG_TICKS = 1000
) (
    input  logic                    iSysClk,
    input  logic                    iSysRstn,
    input  logic                    iCke,
    input  logic [NCH-1:0]          iUserSw,
    output logic [NCH-1:0]          oLevel,
    output logic [NCH-1:0]          oPress,
    output logic [NCH-1:0]          oRelease,
    output logic [NCH-1:0]          oLong,
    output logic                    oEvtVld,
    output logic [sw_chw(NCH)-1:0]  oEvtCh,
    output logic [1:0]              oEvtKind,
    input  logic                    iEvtRdy,
    output logic                    oEvtOvf
);
    localparam int CHW = sw_chw(NCH);
`ifdef SW_LONG_PRESS_EN
    localparam int NK = 3;
`else
    localparam int NK = 2;
`endif

    // Pending bit index: channel*NK + kind.
    logic [NCH*NK-1:0] r_pend;
    logic [NCH*NK-1:0] w_set;
    logic [NCH*NK-1:0] w_clr;
    logic              r_vld;
    logic [CHW-1:0]    r_ch;
    sw_evt_kind_e      r_kind;
    logic              r_ovf;
    logic              w_load;
    logic              w_found;
    logic [CHW-1:0]    w_sel_ch;
    sw_evt_kind_e      w_sel_kind;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        sw_debounce_ch #(
            .DEPTH      (DEPTH),
            .ACT_LOW    (ACT_LOW),
            .LONG_TICKS (LONG_TICKS)
        ) u_ch (
            .i_clk     (iSysClk),
            .i_rst_n   (iSysRstn),
            .i_cke     (iCke),
            .i_raw     (iUserSw[g]),
            .o_level   (oLevel[g]),
            .o_press   (oPress[g]),
            .o_release (oRelease[g]),
            .o_long    (oLong[g])
        );
        assign w_set[g*NK+0] = oPress[g];
        assign w_set[g*NK+1] = oRelease[g];
`ifdef SW_LONG_PRESS_EN
        assign w_set[g*NK+2] = oLong[g];
`endif
    end

    assign w_load = !r_vld || iEvtRdy;

    // Scan from the top so the lowest pending channel is the last (winning) assignment.
    always_comb begin
        w_found    = 1'b0;
        w_sel_ch   = '0;
        w_sel_kind = PRESS;
        w_clr      = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (|r_pend[c*NK +: NK]) begin
                w_found  = 1'b1;
                w_sel_ch = CHW'(c);
                w_clr    = '0;
                if (r_pend[c*NK+0]) begin
                    w_sel_kind       = PRESS;
                    w_clr[c*NK+0]    = 1'b1;
`ifdef SW_LONG_PRESS_EN
                end else if (r_pend[c*NK+2]) begin
                    w_sel_kind       = LONG;
                    w_clr[c*NK+2]    = 1'b1;
`endif
                end else begin
                    w_sel_kind       = RELEASE;
                    w_clr[c*NK+1]    = 1'b1;
                end
            end
        end
        if (!w_load) begin
            w_clr = '0;
        end
    end

    always_ff @(posedge iSysClk or negedge iSysRstn) begin
        if (!iSysRstn) begin
            r_pend <= '0;
            r_vld  <= 1'b0;
            r_ch   <= '0;
            r_kind <= PRESS;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (|(w_set & r_pend)) begin
                r_ovf <= 1'b1;
            end
            if (w_load) begin
                r_vld <= w_found;
                if (w_found) begin
                    r_ch   <= w_sel_ch;
                    r_kind <= w_sel_kind;
                end
            end
        end
    end

    assign oEvtVld  = r_vld;
    assign oEvtCh   = r_ch;
    assign oEvtKind = r_kind;
    assign oEvtOvf  = r_ovf;

endmodule

// File: tb/tb_sw_debounce_bank.sv
// Bench for sw_debounce_bank: directed scenarios plus randomized traffic against a run-length model.
`timescale 1ns/1ps
module tb_sw_debounce_bank;
    import sw_pkg::*;

    localparam int NCH   = 4;
    localparam int DEPTH = 3;
    localparam int LT    = 5;
`ifdef SW_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           cke   = 1'b0;
    logic           rdy   = 1'b0;
    logic [NCH-1:0] raw   = '0;
    logic [NCH-1:0] lvl, prs, rel, lng;
    logic           vld, ovf;
    logic [1:0]     ech;
    logic [1:0]     kind;

    logic [1:0]     raw_b = 2'b11;
    logic           rdy_b = 1'b1;
    logic [1:0]     lvl_b, prs_b, rel_b, lng_b;
    logic           vld_b, ovf_b;
    logic [0:0]     ech_b;
    logic [1:0]     kind_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sw_debounce_bank #(.NCH(NCH), .DEPTH(DEPTH), .ACT_LOW(0), .LONG_TICKS(LT)) u_dut (
        .iSysClk(clk), .iSysRstn(rst_n), .iCke(cke), .iUserSw(raw),
        .oLevel(lvl), .oPress(prs), .oRelease(rel), .oLong(lng),
        .oEvtVld(vld), .oEvtCh(ech), .oEvtKind(kind), .iEvtRdy(rdy), .oEvtOvf(ovf)
    );

    sw_debounce_bank #(.NCH(2), .DEPTH(DEPTH), .ACT_LOW(1), .LONG_TICKS(LT)) u_dut_b (
        .iSysClk(clk), .iSysRstn(rst_n), .iCke(cke), .iUserSw(raw_b),
        .oLevel(lvl_b), .oPress(prs_b), .oRelease(rel_b), .oLong(lng_b),
        .oEvtVld(vld_b), .oEvtCh(ech_b), .oEvtKind(kind_b), .iEvtRdy(rdy_b), .oEvtOvf(ovf_b)
    );

    // Reference model: level follows the value of the trailing run of samples once that run
    // reaches DEPTH; inputs reach the sampler two clocks late.
    bit m_d0[NCH], m_d1[NCH], m_runv[NCH], m_lvl[NCH];
    bit m_prs[NCH], m_rel[NCH], m_lng[NCH];
    int m_run[NCH], m_cnt[NCH];
    bit m_pend[NCH][3];
    bit m_vld, m_ovf;
    int m_ch, m_kind;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_d0[c] = 0; m_d1[c] = 0; m_runv[c] = 0; m_run[c] = DEPTH; m_lvl[c] = 0;
            m_prs[c] = 0; m_rel[c] = 0; m_lng[c] = 0; m_cnt[c] = 0;
            for (int k = 0; k < 3; k++) m_pend[c][k] = 0;
        end
        m_vld = 0; m_ovf = 0; m_ch = 0; m_kind = 0;
    endtask

    task automatic model_step();
        bit np[NCH][3];
        bit found;
        bit lvl_new;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 3; k++) np[c][k] = m_pend[c][k];
        if (!m_vld || rdy) begin
            found = 0;
            for (int c = 0; c < NCH; c++) begin
                if (!found) begin
                    if (m_pend[c][0])      begin found = 1; m_ch = c; m_kind = 0; np[c][0] = 0; end
                    else if (m_pend[c][2]) begin found = 1; m_ch = c; m_kind = 2; np[c][2] = 0; end
                    else if (m_pend[c][1]) begin found = 1; m_ch = c; m_kind = 1; np[c][1] = 0; end
                end
            end
            m_vld = found;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_prs[c]) begin if (m_pend[c][0]) m_ovf = 1; np[c][0] = 1; end
            if (m_rel[c]) begin if (m_pend[c][1]) m_ovf = 1; np[c][1] = 1; end
            if (m_lng[c]) begin if (m_pend[c][2]) m_ovf = 1; np[c][2] = 1; end
        end
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 3; k++) m_pend[c][k] = np[c][k];
        for (int c = 0; c < NCH; c++) begin
            lvl_new  = (m_run[c] >= DEPTH) ? m_runv[c] : m_lvl[c];
            m_lng[c] = 0;
            if (!m_lvl[c]) m_cnt[c] = 0;
            else if (cke && m_cnt[c] < LT) begin
                m_cnt[c]++;
                m_lng[c] = LONG_EN && (m_cnt[c] == LT);
            end
            m_prs[c] = lvl_new && !m_lvl[c];
            m_rel[c] = !lvl_new && m_lvl[c];
            m_lvl[c] = lvl_new;
            if (cke) begin
                if (m_d1[c] == m_runv[c]) begin
                    if (m_run[c] < DEPTH) m_run[c]++;
                end else begin
                    m_runv[c] = m_d1[c];
                    m_run[c]  = 1;
                end
            end
            m_d1[c] = m_d0[c];
            m_d0[c] = raw[c];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic logic [4*NCH+1:0] exp_flags();
        logic [4*NCH+1:0] v;
        for (int c = 0; c < NCH; c++) begin
            v[c] = m_lvl[c]; v[NCH+c] = m_prs[c]; v[2*NCH+c] = m_rel[c]; v[3*NCH+c] = m_lng[c];
        end
        v[4*NCH] = m_vld; v[4*NCH+1] = m_ovf;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; cke = 1; rdy = 1; raw = '0;
        repeat (3) tick();
        vectors++;
        if ({ovf, vld, lng, rel, prs, lvl} !== '0) begin
            errors++; $display("FAIL reset_flags got=%h exp=0", {ovf, vld, lng, rel, prs, lvl});
        end
        vectors++;
        if ({ech, kind} !== 4'h0) begin
            errors++; $display("FAIL reset_slot got ch=%0d kind=%0d exp 0/0", ech, kind);
        end
        rst_n = 1;
        repeat (4) tick();
    endtask

    task automatic test_latency();
        raw = '0; rdy = 1; cke = 1;
        repeat (4) tick();
        raw[0] = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            vectors++;
            if ({ovf, vld, lng, rel, prs, lvl} !== exp_flags()) begin
                errors++; $display("FAIL latency_model k=%0d got=%h exp=%h", k, {ovf, vld, lng, rel, prs, lvl}, exp_flags());
            end
            if (k == 4) begin
                vectors++;
                if (lvl[0] !== 1'b0) begin errors++; $display("FAIL latency_early level=%b exp=0", lvl[0]); end
            end
            if (k == 5) begin
                vectors++;
                if ({lvl[0], prs[0]} !== 2'b11) begin errors++; $display("FAIL latency_edge lvl/press=%b exp=11", {lvl[0], prs[0]}); end
            end
            if (k == 7) begin
                vectors++;
                if ({vld, ech, kind} !== 5'b1_00_00) begin
                    errors++; $display("FAIL latency_event vld=%b ch=%0d kind=%0d exp 1/0/0", vld, ech, kind);
                end
            end
        end
        raw[0] = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_glitch();
        int np, nr;
        np = 0; nr = 0; rdy = 1; cke = 1;
        raw[1] = 1'b1; tick(); tick(); raw[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            np += int'(prs[1]); nr += int'(rel[1]) + int'(lvl[1]) + int'(vld);
        end
        vectors++;
        if (np + nr != 0) begin errors++; $display("FAIL glitch_quiet events=%0d exp=0", np + nr); end
        np = 0;
        raw[1] = 1; tick(); raw[1] = 0; tick(); raw[1] = 1;
        for (int k = 0; k < 15; k++) begin tick(); np += int'(prs[1]); end
        vectors++;
        if (np != 1) begin errors++; $display("FAIL bounce_press count=%0d exp=1", np); end
        raw[1] = 0;
        repeat (12) tick();
    endtask

    task automatic test_long();
        int tp, tl, nl, np;
        bit got_rel;
        tp = -1; tl = -1; nl = 0; np = 0; got_rel = 0; rdy = 1; cke = 1;
        raw[2] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            vectors++;
            if ({ovf, vld, lng, rel, prs, lvl} !== exp_flags()) begin
                errors++; $display("FAIL long_model k=%0d got=%h exp=%h", k, {ovf, vld, lng, rel, prs, lvl}, exp_flags());
            end
            if (prs[2]) begin tp = k; np++; end
            if (lng[2]) begin tl = k; nl++; end
        end
        vectors++;
        if (np != 1 || nl != int'(LONG_EN)) begin
            errors++; $display("FAIL long_count press=%0d long=%0d exp 1/%0d", np, nl, LONG_EN);
        end
        vectors++;
        if (tl != (LONG_EN ? tp + LT : -1)) begin
            errors++; $display("FAIL long_time got=%0d press_at=%0d", tl, tp);
        end
        raw[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (vld && ech == 2'd2 && kind == 2'd1) got_rel = 1;
        end
        vectors++;
        if (!got_rel) begin errors++; $display("FAIL long_release got=0 exp=1"); end
    endtask

    task automatic test_back_to_back();
        rdy = 0; cke = 1;
        raw[1] = 1'b1; raw[3] = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({vld, ech, kind} !== 5'b1_01_00) begin
                errors++; $display("FAIL b2b_hold k=%0d vld=%b ch=%0d kind=%0d exp 1/1/0", k, vld, ech, kind);
            end
            tick();
        end
        rdy = 1;
        tick();
        vectors++;
        if ({vld, ech, kind} !== 5'b1_11_00) begin
            errors++; $display("FAIL b2b_next vld=%b ch=%0d kind=%0d exp 1/3/0", vld, ech, kind);
        end
        tick();
        vectors++;
        if (vld !== 1'b0) begin errors++; $display("FAIL b2b_drain vld=%b exp=0", vld); end
        raw[1] = 1'b0; raw[3] = 1'b0;
        repeat (14) tick();
    endtask

    task automatic test_overflow();
        rdy = 0; cke = 1;
        raw[3] = 1'b1; repeat (8) tick();
        raw[0] = 1'b1; repeat (8) tick();
        raw[0] = 1'b0; repeat (8) tick();
        vectors++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early ovf=%b exp=0", ovf); end
        raw[0] = 1'b1; repeat (8) tick();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky k=%0d ovf=%b exp=1", k, ovf); end
            tick();
        end
        rst_n = 0;
        #1;
        vectors++;
        if ({ovf, vld, lng, rel, prs, lvl, ech, kind} !== '0) begin
            errors++; $display("FAIL ovf_reset got=%h exp=0", {ovf, vld, lng, rel, prs, lvl, ech, kind});
        end
        tick(); tick();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if ({lvl[0], prs[0], lvl[3], prs[3]} !== ((k == 5) ? 4'b1111 : 4'b0000)) begin
                errors++; $display("FAIL repress k=%0d got=%b", k, {lvl[0], prs[0], lvl[3], prs[3]});
            end
        end
        raw = '0; rdy = 1;
        repeat (15) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 7) == 0) raw[c] = ~raw[c];
            cke = ($urandom_range(0, 3) != 0);
            rdy = $urandom_range(0, 1) == 1;
            tick();
            vectors++;
            if ({ovf, vld, lng, rel, prs, lvl} !== exp_flags()) begin
                errors++; $display("FAIL rand_flags k=%0d got=%h exp=%h", k, {ovf, vld, lng, rel, prs, lvl}, exp_flags());
            end
            if (m_vld) begin
                vectors++;
                if ({ech, kind} !== {2'(m_ch), 2'(m_kind)}) begin
                    errors++; $display("FAIL rand_event k=%0d got ch=%0d kind=%0d exp ch=%0d kind=%0d", k, ech, kind, m_ch, m_kind);
                end
            end
        end
        raw = '0; cke = 1; rdy = 1;
        repeat (20) tick();
    endtask

    task automatic test_act_low();
        raw_b = 2'b11; cke = 1;
        rst_n = 0; tick(); tick(); rst_n = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if ({lvl_b, prs_b, vld_b} !== 5'b0) begin
                errors++; $display("FAIL actlow_idle k=%0d got=%b exp=0", k, {lvl_b, prs_b, vld_b});
            end
        end
        raw_b[0] = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            if (k == 4 || k == 5) begin
                vectors++;
                if ({lvl_b[0], prs_b[0]} !== ((k == 5) ? 2'b11 : 2'b00)) begin
                    errors++; $display("FAIL actlow_press k=%0d got=%b", k, {lvl_b[0], prs_b[0]});
                end
            end
            if (k == 7) begin
                vectors++;
                if ({vld_b, ech_b, kind_b} !== 4'b1_0_00) begin
                    errors++; $display("FAIL actlow_event vld=%b ch=%0d kind=%0d exp 1/0/0", vld_b, ech_b, kind_b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_long();
        test_back_to_back();
        test_overflow();
        test_random();
        test_act_low();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
